// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped data memory: I/O window size and register offsets.
package mmio_pkg;
  localparam int IO_WORDS = 8;
  localparam int OUT0_OFS = 0;
  localparam int BTN_OFS  = 4;
  localparam int SW0_OFS  = 5;

  typedef enum logic {
    RD_IO  = 1'b0,
    RD_RAM = 1'b1
  } rd_src_e;
endpackage

// File: rtl/sync2.sv
// Parametrised-width two-flop synchroniser, synchronous active-high reset.
// Latency 2 cycles from d to q; no backpressure.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/mmio_data_memory.sv
// Word RAM with a top-of-map 8-word I/O window (output ports, button status, switch banks).
// Read latency 1 cycle, rdata held between reads; no backpressure, a write beats a same-cycle read.
module mmio_data_memory
  import mmio_pkg::*;
#(
  parameter int N    = 8,
  parameter int M    = 8,
  parameter int NOUT = 1,
  parameter int NIN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [M-1:0]      addr,
  input  logic [N-1:0]      wdata,
  input  logic              we,
  input  logic              re,
  output logic [N-1:0]      rdata,
  output logic              rvalid,
  input  logic              btn_in,
  input  logic [NIN*N-1:0]  sw_in,
  output logic [NOUT*N-1:0] out_port
);
  localparam int DEPTH = 2**M - IO_WORDS;

  logic [NIN*N-1:0] sw_s;
  logic             btn_s;
  logic             btn_prev;
  logic             btn_evt;
  logic             is_io;
  logic [2:0]       ofs;
  logic             wr_en;
  logic             rd_en;
  logic             stat_rd;
  logic             btn_rise;
  logic [N-1:0]     io_rd;
  logic [N-1:0]     io_q;
  logic [N-1:0]     ram_q;
  logic [N-1:0]     ram [DEPTH];
  rd_src_e          rd_src;

  sync2 #(.W(1)) u_btn_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  sync2 #(.W(NIN*N)) u_sw_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw_in),
    .q   (sw_s)
  );

  // The I/O window is the top 8 words, so it is exactly the addresses with all upper bits set.
  assign is_io    = &addr[M-1:3];
  assign ofs      = addr[2:0];
  assign wr_en    = we & ~rst;
  assign rd_en    = re & ~we & ~rst;
  assign stat_rd  = rd_en & is_io & (int'(ofs) == BTN_OFS);
  assign btn_rise = btn_s & ~btn_prev;

  always_ff @(posedge clk) begin
    if (wr_en && !is_io) begin
      ram[addr] <= wdata;
    end
    if (rd_en && !is_io) begin
      ram_q <= ram[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_port <= '0;
    end else if (wr_en && is_io) begin
      for (int k = 0; k < NOUT; k++) begin
        if (int'(ofs) == OUT0_OFS + k) begin
          out_port[k*N +: N] <= wdata;
        end
      end
    end
  end

  always_comb begin
    io_rd = '0;
    for (int k = 0; k < NOUT; k++) begin
      if (int'(ofs) == OUT0_OFS + k) begin
        io_rd = out_port[k*N +: N];
      end
    end
    if (int'(ofs) == BTN_OFS) begin
      io_rd[1:0] = {btn_s, btn_evt};
    end
    for (int k = 0; k < NIN; k++) begin
      if (int'(ofs) == SW0_OFS + k) begin
        io_rd = sw_s[k*N +: N];
      end
    end
  end

  // A new edge in the same cycle as a clearing status read keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev <= 1'b0;
      btn_evt  <= 1'b0;
    end else begin
      btn_prev <= btn_s;
      if (btn_rise) begin
        btn_evt <= 1'b1;
      end else if (stat_rd) begin
        btn_evt <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      io_q   <= '0;
      rd_src <= RD_IO;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        rd_src <= is_io ? RD_IO : RD_RAM;
        if (is_io) begin
          io_q <= io_rd;
        end
      end
    end
  end

  assign rdata = (rd_src == RD_RAM) ? ram_q : io_q;
endmodule

// File: tb/tb_mmio_data_memory.sv
// Bench for mmio_data_memory at N=8, M=8, NOUT=1, NIN=1: read expectations are queued at issue and checked on rvalid.
module tb_mmio_data_memory;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic       re;
  logic [7:0] rdata;
  logic       rvalid;
  logic       btn_in;
  logic [7:0] sw_in;
  logic [7:0] out_port;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem [248];
  int         total = 0;
  int         bad   = 0;
  bit         mon_on = 1'b0;

  mmio_data_memory #(.N(8), .M(8), .NOUT(1), .NIN(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .re       (re),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .btn_in   (btn_in),
    .sw_in    (sw_in),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_on && rvalid === 1'b1) begin
      exp_t e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rvalid rdata=%h required=no_read", rdata);
      end else begin
        e = sb.pop_front();
        if (rdata !== e.d) begin
          bad++;
          $display("FAIL read_data addr=%0d rdata=%h required=%h", e.a, rdata, e.d);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // Tasks start and end just after a falling edge.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; wdata = d; we = 1'b1; re = 1'b0;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.a = a; e.d = d;
    addr = a; re = 1'b1; we = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    addr = 8'd248; wdata = 8'hFF; we = 1'b1; re = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata rdata=%h required=00", rdata); end
    total++;
    if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid rvalid=%b required=0", rvalid); end
    total++;
    if (out_port !== 8'h00) begin bad++; $display("FAIL reset_out_port out_port=%h required=00", out_port); end
    rst = 1'b0; we = 1'b0; re = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    rd(8'd252, 8'h00);
  endtask

  task automatic test_ram;
    logic [7:0] d;
    wr(8'd3, 8'hA5);
    mem[3] = 8'hA5;
    rd(8'd3, 8'hA5);
    total++;
    if (rvalid !== 1'b1) begin bad++; $display("FAIL ram_latency rvalid=%b required=1", rvalid); end
    @(negedge clk);
    total++;
    if (rvalid !== 1'b0 || rdata !== 8'hA5) begin
      bad++; $display("FAIL ram_hold rvalid=%b rdata=%h required=0/a5", rvalid, rdata);
    end
    for (int a = 0; a < 248; a++) begin
      d = 8'($urandom_range(0, 255));
      wr(8'(a), d);
      mem[a] = d;
    end
    for (int a = 0; a < 248; a++) rd(8'(a), mem[a]);
  endtask

  task automatic test_out_port;
    wr(8'd248, 8'h3C);
    total++;
    if (out_port !== 8'h3C) begin bad++; $display("FAIL out_port_write out_port=%h required=3c", out_port); end
    wr(8'd249, 8'hFF);
    wr(8'd252, 8'hFF);
    wr(8'd253, 8'hFF);
    repeat (3) @(negedge clk);
    total++;
    if (out_port !== 8'h3C) begin bad++; $display("FAIL out_port_hold out_port=%h required=3c", out_port); end
    rd(8'd248, 8'h3C);
    rd(8'd249, 8'h00);
    rd(8'd254, 8'h00);
    rd(8'd255, 8'h00);
    rd(8'd253, 8'h00);
    for (int a = 0; a < 248; a++) rd(8'(a), mem[a]);
  endtask

  task automatic test_switch;
    sw_in = 8'h81;
    repeat (2) @(negedge clk);
    rd(8'd253, 8'h81);
    sw_in = 8'h5E;
    repeat (2) @(negedge clk);
    rd(8'd253, 8'h5E);
  endtask

  task automatic test_button;
    btn_in = 1'b1;
    repeat (3) @(negedge clk);
    btn_in = 1'b0;
    rd(8'd252, 8'h03);
    repeat (3) @(negedge clk);
    rd(8'd252, 8'h00);
    btn_in = 1'b1;
    repeat (2) @(negedge clk);
    rd(8'd252, 8'h02);
    rd(8'd252, 8'h03);
    btn_in = 1'b0;
    repeat (3) @(negedge clk);
    rd(8'd252, 8'h00);
  endtask

  task automatic test_collision;
    addr = 8'd10; wdata = 8'h5A; we = 1'b1; re = 1'b1;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    mem[10] = 8'h5A;
    total++;
    if (rvalid !== 1'b0) begin bad++; $display("FAIL collision_rvalid rvalid=%b required=0", rvalid); end
    rd(8'd10, 8'h5A);
  endtask

  task automatic test_back_to_back;
    wr(8'd100, 8'h11);
    rd(8'd100, 8'h11);
    wr(8'd247, 8'hE7);
    rd(8'd247, 8'hE7);
    rd(8'd100, 8'h11);
    mem[100] = 8'h11;
    mem[247] = 8'hE7;
  endtask

  task automatic test_mid_reset;
    btn_in = 1'b1;
    repeat (4) @(negedge clk);
    btn_in = 1'b0;
    repeat (4) @(negedge clk);
    wr(8'd248, 8'h77);
    total++;
    if (out_port !== 8'h77) begin bad++; $display("FAIL pre_reset_out out_port=%h required=77", out_port); end
    rst = 1'b1; addr = 8'd252; re = 1'b1;
    @(negedge clk);
    rst = 1'b0; re = 1'b0;
    total++;
    if (rvalid !== 1'b0) begin bad++; $display("FAIL mid_reset_rvalid rvalid=%b required=0", rvalid); end
    total++;
    if (out_port !== 8'h00) begin bad++; $display("FAIL mid_reset_out out_port=%h required=00", out_port); end
    total++;
    if (rdata !== 8'h00) begin bad++; $display("FAIL mid_reset_rdata rdata=%h required=00", rdata); end
    rd(8'd252, 8'h00);
    rd(8'd3, mem[3]);
    rd(8'd10, mem[10]);
    rd(8'd247, mem[247]);
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    btn_in = 1'b0; sw_in = '0;
    @(negedge clk);
    test_reset();
    test_ram();
    test_out_port();
    test_switch();
    test_button();
    test_collision();
    test_back_to_back();
    test_mid_reset();
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL pending_reads outstanding=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
